// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Imported by the loader top and its byte assembler.
package loader_pkg;

    localparam int DEPTH          = 1024;
    localparam int ADDR_W         = 10;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs accepted stream bytes into little-endian 32-bit words.
// word_valid_o pulses combinationally with the 4th byte of a word.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [23:0] sh_q;

    // Byte counter and low three bytes, shifted in LSB-first
    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            cnt_q <= '0;
            sh_q  <= '0;
        end else if (byte_valid_i) begin
            cnt_q <= cnt_q + 2'd1;
            sh_q  <= {byte_i, sh_q[23:8]};
        end
    end

    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = {byte_i, sh_q};

endmodule

// File: rtl/prog_loader.sv
// Loads a checksummed program image into instruction memory,
// holding the core in reset until the image is verified.
module prog_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = loader_pkg::DEPTH,
    parameter int ADDR_W = loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [15:0]   DEPTH16 = 16'(DEPTH);
    localparam logic [ADDR_W:0] ONE   = 1;

    loader_state_t     state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              wren_q, wren_d;

    logic        accept;
    logic        byte_valid;
    logic [31:0] word;
    logic        word_valid;
    logic [15:0] len_full;
    logic [ADDR_W:0] wl_inc;

    assign in_ready = rst && (state_q == S_LEN0 || state_q == S_LEN1 ||
                              state_q == S_DATA || state_q == S_CHK);
    // A byte alongside restart is dropped so the new frame starts clean
    assign accept     = in_valid && in_ready && !restart;
    assign byte_valid = accept && (state_q == S_DATA);
    assign len_full   = {len_hi_q, in_data};
    assign wl_inc     = wl_q + ONE;

    byte_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (restart),
        .byte_valid_i(byte_valid),
        .byte_i      (in_data),
        .word_o      (word),
        .word_valid_o(word_valid)
    );

    // Frame FSM: length, payload with running XOR, checksum
    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        n_d      = n_q;
        xor_d    = xor_q;
        wl_d     = wl_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        if (restart) begin
            state_d = S_LEN0;
            xor_d   = '0;
            wl_d    = '0;
        end else if (accept) begin
            unique case (state_q)
                S_LEN0: begin
                    len_hi_d = in_data;
                    state_d  = S_LEN1;
                end
                S_LEN1: begin
                    if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else if (len_full > DEPTH16) begin
                        state_d = S_ERR;
                    end else begin
                        n_d     = len_full[ADDR_W:0];
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    xor_d = xor_q ^ in_data;
                    if (word_valid) begin
                        wren_d = 1'b1;
                        data_d = word;
                        addr_d = wl_q[ADDR_W-1:0];
                        wl_d   = wl_inc;
                        if (wl_inc == n_q) begin
                            state_d = S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    state_d = (in_data == xor_q) ? S_DONE : S_ERR;
                end
                default: ;
            endcase
        end
    end

    // State, counters and registered memory write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_LEN0;
            len_hi_q <= '0;
            n_q      <= '0;
            xor_q    <= '0;
            wl_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wren_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            n_q      <= n_d;
            xor_q    <= xor_d;
            wl_q     <= wl_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign mem_wren     = wren_q;
    assign words_loaded = wl_q;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign cpu_rst      = (state_q != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame table plus
// hand-written reset/restart/boundary sequences, write scoreboard.
module tb_prog_loader;
    import loader_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              restart = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic              cpu_rst;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          bad_chk;
        int          gap_pct;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[6];

    prog_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .restart     (restart),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .error       (error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst && mem_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         mem_addr, mem_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.a));
                check("wr_data", mem_data, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit acc;
        acc = 1'b0;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) tick();
        in_data  = b;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_byte_timeout: got in_ready 0 expected 1");
        end
    endtask

    function automatic logic [31:0] word_of(input int i, input logic [31:0] w0,
                                            input logic [31:0] w1);
        if (i == 0) return w0;
        if (i == 1) return w1;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Sends one complete frame; payload writes go onto the scoreboard
    task automatic send_frame(input logic [15:0] len, input logic [31:0] w0,
                              input logic [31:0] w1, input bit bad,
                              input int gap_pct);
        logic [7:0]  x;
        logic [31:0] w;
        wr_t         e;
        x = '0;
        send_byte(len[15:8], gap_pct);
        send_byte(len[7:0], gap_pct);
        if (len > 16'(DEPTH)) return;
        for (int i = 0; i < int'(len); i++) begin
            w   = word_of(i, w0, w1);
            e.a = ADDR_W'(i);
            e.d = w;
            exp_q.push_back(e);
            for (int b = 0; b < 4; b++) begin
                x = x ^ w[8*b +: 8];
                send_byte(w[8*b +: 8], gap_pct);
            end
        end
        send_byte(x ^ {7'd0, bad}, gap_pct);
    endtask

    task automatic check_end(input string tag, input bit d, input bit e,
                             input int words);
        tick();
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!d));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        check({tag, "_words"}, 32'(words_loaded), 32'(words));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0002, 32'h0000_0013, 32'h0010_0093, 0, 0,  1, 0, 2};
        vecs[1] = '{16'h0002, 32'h0000_0013, 32'h0010_0093, 1, 0,  0, 1, 2};
        vecs[2] = '{16'h0401, 32'h0,         32'h0,         0, 0,  0, 1, 0};
        vecs[3] = '{16'h0000, 32'h0,         32'h0,         0, 0,  1, 0, 0};
        vecs[4] = '{16'h0002, 32'h0000_0013, 32'h0010_0093, 0, 30, 1, 0, 2};
        vecs[5] = '{16'h0001, 32'hDEAD_BEEF, 32'h0,         0, 20, 1, 0, 1};

        // Reset values while rst is held low
        rst = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_cpu_rst", 32'(cpu_rst), 32'(1));
        check("rst_done", 32'(done), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_words", 32'(words_loaded), 32'(0));
        check("rst_wren", 32'(mem_wren), 32'(0));
        check("rst_addr", 32'(mem_addr), 32'(0));
        check("rst_data", mem_data, 32'(0));
        rst = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'(1));

        // Table of frames; restart between them also covers leaving S_ERR
        foreach (vecs[i]) begin
            pulse_restart();
            check("restart_cpu_rst", 32'(cpu_rst), 32'(1));
            check("restart_flags", 32'({done, error}), 32'(0));
            check("restart_words", 32'(words_loaded), 32'(0));
            send_frame(vecs[i].len, vecs[i].w0, vecs[i].w1, vecs[i].bad_chk,
                       vecs[i].gap_pct);
            check_end($sformatf("vec%0d", i), vecs[i].exp_done,
                      vecs[i].exp_err, vecs[i].exp_words);
        end

        // Reset mid-frame after 6 payload bytes, then a full reload
        pulse_restart();
        begin
            wr_t e;
            e.a = '0;
            e.d = 32'h1122_3344;
            exp_q.push_back(e);
        end
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        send_byte(8'h22, 0);
        send_byte(8'h11, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rst = 1'b0;
        tick();
        check("midrst_words", 32'(words_loaded), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(0));
        check("midrst_cpu_rst", 32'(cpu_rst), 32'(1));
        rst = 1'b1;
        tick();
        send_frame(16'h0001, 32'hCAFE_F00D, 32'h0, 0, 0);
        check_end("midrst_reload", 1, 0, 1);

        // A byte presented together with restart must be discarded
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h05;
        tick();
        restart  = 1'b0;
        in_valid = 1'b0;
        send_frame(16'h0001, 32'h0000_0073, 32'h0, 0, 0);
        check_end("restart_byte", 1, 0, 1);

        // Full-depth image: last word lands at index DEPTH-1
        pulse_restart();
        send_frame(16'(DEPTH), 32'h0000_0013, 32'h0010_0093, 0, 0);
        check_end("full_depth", 1, 0, DEPTH);
        check("full_depth_last_addr", 32'(mem_addr), 32'(DEPTH - 1));

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
